// File: rtl/ad9833_pkg.sv
// ---------------------------------------------------------------------------
// ad9833_pkg
// Shared definitions for the AD9833 serial receiver: receiver FSM states,
// address-field codes of the 16-bit word, control-bit positions, register
// widths and the FREQ register update helper.
// ---------------------------------------------------------------------------
package ad9833_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } rx_state_t;

   // Address field w[15:14]
   localparam logic [1:0] ADDR_CTRL  = 2'b00;
   localparam logic [1:0] ADDR_FREQ0 = 2'b01;
   localparam logic [1:0] ADDR_FREQ1 = 2'b10;
   localparam logic [1:0] ADDR_PHASE = 2'b11;

   // Control-register bit positions
   localparam int B28 = 13;
   localparam int HLB = 12;

   // Register widths
   localparam int FREQ_W  = 28;
   localparam int PHASE_W = 12;

   // Next value of a FREQ register for a 14-bit data field d.
   // With B28 set, the first write of a pair only stages LSBs (register
   // unchanged); the second write commits {d, staged LSBs}.
   function automatic logic [FREQ_W-1:0] freq_next(
      input logic [FREQ_W-1:0] old_val,
      input logic [13:0]       d,
      input logic              b28,
      input logic              hlb,
      input logic              pend,
      input logic [13:0]       stage
   );
      logic [FREQ_W-1:0] r_val;
      if (b28) begin
         if (pend) begin
            r_val = {d, stage};
         end else begin
            r_val = old_val;
         end
      end else if (hlb) begin
         r_val = {d, old_val[13:0]};
      end else begin
         r_val = {old_val[27:14], d};
      end
      return r_val;
   endfunction

endpackage

// File: rtl/ad9833_rx_if.sv
// ---------------------------------------------------------------------------
// ad9833_rx_if
// The AD9833 three-wire serial bus.
//   fsync : frame select, active low
//   sclk  : serial clock
//   sdata : serial data, MSB first
// master = the word transmitter, slave = the receiver.
// ---------------------------------------------------------------------------
interface ad9833_rx_if;
   logic fsync;
   logic sclk;
   logic sdata;

   modport master (output fsync, output sclk, output sdata);
   modport slave  (input  fsync, input  sclk, input  sdata);
endinterface

// File: rtl/ad9833_pin_sync.sv
// ---------------------------------------------------------------------------
// ad9833_pin_sync
// Synchroniser chain plus one history flop for one asynchronous pin.
//   clk, rst_n : system clock, async active-low reset
//   i_pin      : raw asynchronous pin
//   o_level    : synchronised level
//   o_rise     : synchronised level high, history low (one-cycle pulse)
//   o_fall     : synchronised level low, history high (one-cycle pulse)
// Everything resets to 0, so a pin already low at reset release never
// produces a fall.
// ---------------------------------------------------------------------------
module ad9833_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   // Synchroniser chain and history flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/ad9833_rx.sv
// ---------------------------------------------------------------------------
// ad9833_rx
// AD9833 serial receiver: oversamples FSYNC/SCLK/SDATA, deserialises 16-bit
// words framed by FSYNC and decodes them into the AD9833 register image.
//   clk, rst_n : system clock, async active-low reset
//   bus        : serial pins (slave modport)
//   word_valid : one-cycle pulse per completed word
//   word_data  : last completed word
//   frame_err  : one-cycle pulse when FSYNC rises mid-word (1..15 bits)
//   ctrl_reg, freq0_reg, freq1_reg, phase0_reg, phase1_reg : register image
//   word_count : completed words, wraps at 256
// ---------------------------------------------------------------------------
module ad9833_rx
   import ad9833_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   ad9833_rx_if.slave          bus,
   output logic                word_valid,
   output logic [15:0]         word_data,
   output logic                frame_err,
   output logic [15:0]         ctrl_reg,
   output logic [FREQ_W-1:0]   freq0_reg,
   output logic [FREQ_W-1:0]   freq1_reg,
   output logic [PHASE_W-1:0]  phase0_reg,
   output logic [PHASE_W-1:0]  phase1_reg,
   output logic [7:0]          word_count
);

   logic w_fsync_lvl, w_fsync_rise, w_fsync_fall;
   logic w_sclk_rise, w_sdata_lvl;
   logic w_unused_sclk_lvl, w_unused_sclk_fall;
   logic w_unused_sdata_rise, w_unused_sdata_fall;

   ad9833_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fsync (
      .clk(clk), .rst_n(rst_n), .i_pin(bus.fsync),
      .o_level(w_fsync_lvl), .o_rise(w_fsync_rise), .o_fall(w_fsync_fall));

   ad9833_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .i_pin(bus.sclk),
      .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_unused_sclk_fall));

   ad9833_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
      .clk(clk), .rst_n(rst_n), .i_pin(bus.sdata),
      .o_level(w_sdata_lvl), .o_rise(w_unused_sdata_rise), .o_fall(w_unused_sdata_fall));

   rx_state_t          r_state, w_state_nxt;
   logic [3:0]         r_bit_cnt;
   logic [15:0]        r_shift;
   logic               r_word_valid, r_frame_err;
   logic [15:0]        r_word_data, r_ctrl;
   logic [FREQ_W-1:0]  r_freq0, r_freq1;
   logic [PHASE_W-1:0] r_phase0, r_phase1;
   logic [7:0]         r_word_count;
   logic               r_pair_pend;
   logic [13:0]        r_lsb_stage;

   logic        w_capture, w_word_done, w_abort_err, w_clr_cnt;
   logic [15:0] w_word;

   // The completed word includes the bit being captured this cycle
   assign w_word = {r_shift[14:0], w_sdata_lvl};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; fsync_rise wins over a simultaneous sclk_rise
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_fsync_fall) w_state_nxt = ST_SHIFT;
            else              w_state_nxt = ST_IDLE;
         end
         ST_SHIFT: begin
            if (w_fsync_rise)                          w_state_nxt = ST_IDLE;
            else if (w_sclk_rise && r_bit_cnt == 4'd15) w_state_nxt = ST_DONE;
            else                                       w_state_nxt = ST_SHIFT;
         end
         ST_DONE: begin
            if (!w_fsync_lvl) w_state_nxt = ST_SHIFT;
            else              w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM output decode; completion is flagged on the 16th capture so the
   // registered outputs change on the edge that enters DONE
   always_comb begin
      w_capture   = (r_state == ST_SHIFT) && !w_fsync_rise && w_sclk_rise;
      w_word_done = w_capture && (r_bit_cnt == 4'd15);
      w_abort_err = (r_state == ST_SHIFT) && w_fsync_rise && (r_bit_cnt != 4'd0);
      w_clr_cnt   = ((r_state == ST_IDLE) && w_fsync_fall) ||
                    ((r_state == ST_DONE) && !w_fsync_lvl);
   end

   // Bit counter, shift register and pulse outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt    <= 4'd0;
         r_shift      <= 16'd0;
         r_word_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         if (w_clr_cnt)      r_bit_cnt <= 4'd0;
         else if (w_capture) r_bit_cnt <= r_bit_cnt + 4'd1;
         if (w_capture)      r_shift   <= w_word;
         r_word_valid <= w_word_done;
         r_frame_err  <= w_abort_err;
      end
   end

   // Word capture and register-image decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_data  <= 16'd0;
         r_word_count <= 8'd0;
         r_ctrl       <= 16'd0;
         r_freq0      <= '0;
         r_freq1      <= '0;
         r_phase0     <= '0;
         r_phase1     <= '0;
         r_pair_pend  <= 1'b0;
         r_lsb_stage  <= 14'd0;
      end else if (w_word_done) begin
         r_word_data  <= w_word;
         r_word_count <= r_word_count + 8'd1;
         case (w_word[15:14])
            ADDR_CTRL: begin
               r_ctrl      <= {2'b00, w_word[13:0]};
               r_pair_pend <= 1'b0;
            end
            ADDR_FREQ0, ADDR_FREQ1: begin
               // One pending flag serves both FREQ registers
               if (r_ctrl[B28]) begin
                  r_pair_pend <= ~r_pair_pend;
                  if (!r_pair_pend) r_lsb_stage <= w_word[13:0];
               end
               if (w_word[15:14] == ADDR_FREQ0)
                  r_freq0 <= freq_next(r_freq0, w_word[13:0], r_ctrl[B28],
                                       r_ctrl[HLB], r_pair_pend, r_lsb_stage);
               else
                  r_freq1 <= freq_next(r_freq1, w_word[13:0], r_ctrl[B28],
                                       r_ctrl[HLB], r_pair_pend, r_lsb_stage);
            end
            ADDR_PHASE: begin
               if (w_word[13]) r_phase1 <= w_word[11:0];
               else            r_phase0 <= w_word[11:0];
            end
            default: ;
         endcase
      end
   end

   assign word_valid = r_word_valid;
   assign frame_err  = r_frame_err;
   assign word_data  = r_word_data;
   assign word_count = r_word_count;
   assign ctrl_reg   = r_ctrl;
   assign freq0_reg  = r_freq0;
   assign freq1_reg  = r_freq1;
   assign phase0_reg = r_phase0;
   assign phase1_reg = r_phase1;

endmodule
